// File: rtl/frame_pacer.sv
// frame_pacer: multi-channel frame-rate divider for the block-stacker pipeline.
// Each channel counts frame_tick strobes up to its own period and emits a
// registered one-cycle tick_out on expiry, either periodically or once
// (one-shot, latching done until restarted). Channels share only the inputs.

module frame_pacer #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      frame_tick,
  input  logic [CHANNELS*CNT_W-1:0] period,
  input  logic [CHANNELS-1:0]       run,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS-1:0]       restart,
  output logic [CHANNELS-1:0]       tick_out,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS*CNT_W-1:0] count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q [CHANNELS];
  state_t             state_d [CHANNELS];
  logic [CNT_W-1:0]   cnt_q   [CHANNELS];
  logic [CNT_W-1:0]   cnt_d   [CHANNELS];
  logic [CNT_W-1:0]   limit   [CHANNELS];
  logic [CHANNELS-1:0] tick_q;
  logic [CHANNELS-1:0] tick_d;
  logic [CHANNELS-1:0] done_q;
  logic [CHANNELS-1:0] done_d;

  // Last count value before expiry; a period of 0 behaves like a period of 1.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (period[i*CNT_W +: CNT_W] == '0) begin
        limit[i] = '0;
      end else begin
        limit[i] = period[i*CNT_W +: CNT_W] - 1'b1;
      end
    end
  end

  // State register: reset and per-channel state, counter and output flops.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tick_q <= '0;
      done_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      tick_q <= tick_d;
      done_q <= done_d;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Next-state logic: restart wins, then the per-state counting rules.
  // Expiry compares with >= so a period lowered below the current count
  // expires on the next counted tick instead of wrapping around.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      tick_d[i]  = 1'b0;
      if (restart[i]) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            cnt_d[i] = '0;
            if (run[i]) begin
              state_d[i] = COUNT;
            end
          end
          COUNT: begin
            if (!run[i]) begin
              state_d[i] = PAUSE;
            end else if (frame_tick) begin
              if (cnt_q[i] >= limit[i]) begin
                tick_d[i] = 1'b1;
                cnt_d[i]  = '0;
                if (mode[i]) begin
                  state_d[i] = DONE;
                end
              end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
              end
            end
          end
          PAUSE: begin
            if (run[i]) begin
              state_d[i] = COUNT;
            end
          end
          DONE: begin
            cnt_d[i] = '0;
          end
          default: begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
      done_d[i] = (state_d[i] == DONE);
    end
  end

  // Output logic: every output comes straight from a flop.
  always_comb begin
    tick_out = tick_q;
    done     = done_q;
    count    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      count[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

endmodule

// File: tb/tb_frame_pacer.sv
// tb_frame_pacer: scoreboard bench for frame_pacer with two 4-bit channels.
// Each scenario queues per-cycle stimulus together with the outputs expected
// after the following clock edge, then replays the queue and compares.

module tb_frame_pacer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       frame_tick;
  logic [7:0] period;
  logic [1:0] run;
  logic [1:0] mode;
  logic [1:0] restart;
  logic [1:0] tick_out;
  logic [1:0] done;
  logic [7:0] count;

  typedef struct packed {
    logic       rn;
    logic       ft;
    logic [1:0] run;
    logic [1:0] rs;
    logic [1:0] mode;
    logic [7:0] per;
  } stim_t;

  typedef struct packed {
    logic [1:0] t;
    logic [1:0] d;
    logic [7:0] c;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    tests_run    = 0;
  int    tests_failed = 0;

  frame_pacer #(.CHANNELS(2), .CNT_W(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .frame_tick (frame_tick),
    .period     (period),
    .run        (run),
    .mode       (mode),
    .restart    (restart),
    .tick_out   (tick_out),
    .done       (done),
    .count      (count)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Queue one cycle of stimulus and the outputs expected after its edge.
  task automatic add(input logic rn, input logic ft, input logic [1:0] r,
                     input logic [1:0] rs, input logic [1:0] md, input logic [7:0] per,
                     input logic [1:0] t, input logic [1:0] d, input logic [7:0] c);
    stim_t s;
    exp_t  e;
    s = '{rn: rn, ft: ft, run: r, rs: rs, mode: md, per: per};
    e = '{t: t, d: d, c: c};
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    int n = 0;
    repeat (2) add(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 8'h33, 2'b00, 2'b00, 8'h00);
    for (int k = 0; k < 5; k++) begin
      add(1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 8'h33, 2'b00, 2'b00, 8'h00);
      add(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 8'h33, 2'b00, 2'b00, 8'h00);
    end
    while (stim_q.size() > 0) begin
      stim_t s;
      exp_t  e;
      s = stim_q.pop_front();
      {resetn, frame_tick, run, restart, mode, period} = s;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      tests_run++;
      if ({tick_out, done, count} !== e) begin
        tests_failed++;
        $display("[TB] FAIL reset step %0d: got tick=%b done=%b count=%h, want tick=%b done=%b count=%h",
                 n, tick_out, done, count, e.t, e.d, e.c);
      end
      n++;
    end
  endtask

  task automatic test_periodic();
    int n = 0;
    logic [3:0] c;
    add(1'b1, 1'b0, 2'b00, 2'b11, 2'b00, 8'h03, 2'b00, 2'b00, 8'h00);
    add(1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 8'h03, 2'b00, 2'b00, 8'h00);
    for (int k = 1; k <= 9; k++) begin
      c = 4'(k % 3);
      add(1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 8'h03, (c == 4'd0) ? 2'b01 : 2'b00, 2'b00, {4'h0, c});
      repeat (3) add(1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 8'h03, 2'b00, 2'b00, {4'h0, c});
    end
    while (stim_q.size() > 0) begin
      stim_t s;
      exp_t  e;
      s = stim_q.pop_front();
      {resetn, frame_tick, run, restart, mode, period} = s;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      tests_run++;
      if ({tick_out, done, count} !== e) begin
        tests_failed++;
        $display("[TB] FAIL periodic step %0d: got tick=%b done=%b count=%h, want tick=%b done=%b count=%h",
                 n, tick_out, done, count, e.t, e.d, e.c);
      end
      n++;
    end
  endtask

  task automatic test_oneshot();
    int n = 0;
    logic [1:0] t;
    logic [1:0] d;
    logic [3:0] c;
    logic [1:0] md;
    add(1'b1, 1'b0, 2'b00, 2'b11, 2'b10, 8'h20, 2'b00, 2'b00, 8'h00);
    add(1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 8'h20, 2'b00, 2'b00, 8'h00);
    for (int k = 1; k <= 5; k++) begin
      t  = (k == 2) ? 2'b10 : 2'b00;
      d  = (k >= 2) ? 2'b10 : 2'b00;
      c  = (k == 1) ? 4'd1 : 4'd0;
      md = (k >= 3) ? 2'b00 : 2'b10;
      add(1'b1, 1'b1, 2'b10, 2'b00, md, 8'h20, t, d, {c, 4'h0});
      add(1'b1, 1'b0, 2'b10, 2'b00, md, 8'h20, 2'b00, d, {c, 4'h0});
    end
    add(1'b1, 1'b0, 2'b10, 2'b10, 2'b10, 8'h20, 2'b00, 2'b00, 8'h00);
    add(1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 8'h20, 2'b00, 2'b00, 8'h00);
    add(1'b1, 1'b1, 2'b10, 2'b00, 2'b10, 8'h20, 2'b00, 2'b00, 8'h10);
    add(1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 8'h20, 2'b00, 2'b00, 8'h10);
    add(1'b1, 1'b1, 2'b10, 2'b00, 2'b10, 8'h20, 2'b10, 2'b10, 8'h00);
    add(1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 8'h20, 2'b00, 2'b10, 8'h00);
    while (stim_q.size() > 0) begin
      stim_t s;
      exp_t  e;
      s = stim_q.pop_front();
      {resetn, frame_tick, run, restart, mode, period} = s;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      tests_run++;
      if ({tick_out, done, count} !== e) begin
        tests_failed++;
        $display("[TB] FAIL oneshot step %0d: got tick=%b done=%b count=%h, want tick=%b done=%b count=%h",
                 n, tick_out, done, count, e.t, e.d, e.c);
      end
      n++;
    end
  endtask

  task automatic test_pause();
    int n = 0;
    add(1'b1, 1'b0, 2'b00, 2'b11, 2'b00, 8'h04, 2'b00, 2'b00, 8'h00);
    add(1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 8'h04, 2'b00, 2'b00, 8'h00);
    add(1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 8'h04, 2'b00, 2'b00, 8'h01);
    add(1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 8'h04, 2'b00, 2'b00, 8'h01);
    add(1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 8'h04, 2'b00, 2'b00, 8'h02);
    add(1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 8'h04, 2'b00, 2'b00, 8'h02);
    add(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 8'h04, 2'b00, 2'b00, 8'h02);
    repeat (3) begin
      add(1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 8'h04, 2'b00, 2'b00, 8'h02);
      add(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 8'h04, 2'b00, 2'b00, 8'h02);
    end
    add(1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 8'h04, 2'b00, 2'b00, 8'h02);
    add(1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 8'h04, 2'b00, 2'b00, 8'h03);
    add(1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 8'h04, 2'b00, 2'b00, 8'h03);
    add(1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 8'h04, 2'b01, 2'b00, 8'h00);
    add(1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 8'h04, 2'b00, 2'b00, 8'h00);
    add(1'b1, 1'b0, 2'b00, 2'b11, 2'b00, 8'h00, 2'b00, 2'b00, 8'h00);
    add(1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 8'h00, 2'b00, 2'b00, 8'h00);
    repeat (3) add(1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 8'h00, 2'b01, 2'b00, 8'h00);
    add(1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 8'h00, 2'b00, 2'b00, 8'h00);
    while (stim_q.size() > 0) begin
      stim_t s;
      exp_t  e;
      s = stim_q.pop_front();
      {resetn, frame_tick, run, restart, mode, period} = s;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      tests_run++;
      if ({tick_out, done, count} !== e) begin
        tests_failed++;
        $display("[TB] FAIL pause step %0d: got tick=%b done=%b count=%h, want tick=%b done=%b count=%h",
                 n, tick_out, done, count, e.t, e.d, e.c);
      end
      n++;
    end
  endtask

  task automatic test_period_reduce();
    int n = 0;
    add(1'b1, 1'b0, 2'b00, 2'b11, 2'b00, 8'h08, 2'b00, 2'b00, 8'h00);
    add(1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 8'h08, 2'b00, 2'b00, 8'h00);
    for (int k = 1; k <= 5; k++) begin
      add(1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 8'h08, 2'b00, 2'b00, 8'(k));
      add(1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 8'h08, 2'b00, 2'b00, 8'(k));
    end
    add(1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 8'h03, 2'b01, 2'b00, 8'h00);
    add(1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 8'h03, 2'b00, 2'b00, 8'h00);
    add(1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 8'h03, 2'b00, 2'b00, 8'h01);
    add(1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 8'h03, 2'b00, 2'b00, 8'h01);
    while (stim_q.size() > 0) begin
      stim_t s;
      exp_t  e;
      s = stim_q.pop_front();
      {resetn, frame_tick, run, restart, mode, period} = s;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      tests_run++;
      if ({tick_out, done, count} !== e) begin
        tests_failed++;
        $display("[TB] FAIL period_reduce step %0d: got tick=%b done=%b count=%h, want tick=%b done=%b count=%h",
                 n, tick_out, done, count, e.t, e.d, e.c);
      end
      n++;
    end
  endtask

  task automatic test_simultaneous();
    int n = 0;
    add(1'b1, 1'b0, 2'b00, 2'b11, 2'b00, 8'h03, 2'b00, 2'b00, 8'h00);
    add(1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 8'h03, 2'b00, 2'b00, 8'h00);
    add(1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 8'h03, 2'b00, 2'b00, 8'h01);
    add(1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 8'h03, 2'b00, 2'b00, 8'h02);
    add(1'b1, 1'b1, 2'b01, 2'b01, 2'b00, 8'h03, 2'b00, 2'b00, 8'h00);
    add(1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 8'h03, 2'b00, 2'b00, 8'h00);
    add(1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 8'h03, 2'b00, 2'b00, 8'h01);
    add(1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 8'h03, 2'b00, 2'b00, 8'h02);
    add(1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 8'h03, 2'b00, 2'b00, 8'h00);
    add(1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 8'h03, 2'b00, 2'b00, 8'h00);
    add(1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 8'h03, 2'b00, 2'b00, 8'h01);
    add(1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 8'h03, 2'b00, 2'b00, 8'h02);
    add(1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 8'h03, 2'b01, 2'b00, 8'h00);
    add(1'b1, 1'b1, 2'b01, 2'b01, 2'b00, 8'h03, 2'b00, 2'b00, 8'h00);
    add(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 8'h03, 2'b00, 2'b00, 8'h00);
    while (stim_q.size() > 0) begin
      stim_t s;
      exp_t  e;
      s = stim_q.pop_front();
      {resetn, frame_tick, run, restart, mode, period} = s;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      tests_run++;
      if ({tick_out, done, count} !== e) begin
        tests_failed++;
        $display("[TB] FAIL simultaneous step %0d: got tick=%b done=%b count=%h, want tick=%b done=%b count=%h",
                 n, tick_out, done, count, e.t, e.d, e.c);
      end
      n++;
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    resetn     = 1'b0;
    frame_tick = 1'b0;
    period     = 8'h00;
    run        = 2'b00;
    mode       = 2'b00;
    restart    = 2'b00;
    test_reset();
    test_periodic();
    test_oneshot();
    test_pause();
    test_period_reduce();
    test_simultaneous();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
